// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR latch driver: command opcodes,
// controller states and the per-opcode expected-Q / drive-select rules.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_RST = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SETTLE = 2'b10,
        CHECK  = 2'b11
    } state_e;

    // Q value the latch must show once the command has been applied.
    function automatic logic op_exp_q(input op_e op, input logic q_now);
        logic res;
        case (op)
            OP_SET:  res = 1'b1;
            OP_RST:  res = 1'b0;
            OP_TGL:  res = ~q_now;
            OP_NOP:  res = q_now;
            default: res = q_now;
        endcase
        return res;
    endfunction

    // 1 selects the S line, 0 selects the R line (only meaningful when driving).
    function automatic logic op_sel_s(input op_e op, input logic q_now);
        logic res;
        case (op)
            OP_SET:  res = 1'b1;
            OP_RST:  res = 1'b0;
            OP_TGL:  res = ~q_now;
            OP_NOP:  res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // NOP only checks the held value; every other opcode pulses a line.
    function automatic logic op_drives(input op_e op);
        return (op != OP_NOP);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command-side bundle of the SR latch driver: valid/ready handshake,
// opcode, and the completion / status report back to the command source.
interface sr_latch_driver_if #(
    parameter int unsigned ERR_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             done;
    logic             err;
    logic             q_seen;
    logic [ERR_W-1:0] err_count;

    // Command source side.
    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready,
        input  done,
        input  err,
        input  q_seen,
        input  err_count
    );

    // Driver side.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready,
        output done,
        output err,
        output q_seen,
        output err_count
    );
endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter timing both the pulse and settle intervals.
// A load of N gives N+1 cycles before the zero flag is seen by the FSM.
module sr_pulse_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Load on request, otherwise count down to zero and rest there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked initiator for an SR latch: accepts SET/RESET/TOGGLE/NOP commands,
// drives a single fixed-width S or R pulse, waits for the latch to settle,
// reads Q back and reports pass/mismatch. S and R are derived from one
// select bit gated by the DRIVE state, so both can never be high together.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned SETTLE_W = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    sr_latch_driver_if.slave         bus,
    output logic                     s_out,
    output logic                     r_out,
    input  logic                     q_in
);

    localparam int unsigned      CNT_W     = $clog2(max_u(PULSE_W, SETTLE_W) + 32'd1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 32'd1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    if (PULSE_W < 32'd1) begin : g_bad_pulse_w
        $error("sr_latch_driver: PULSE_W must be at least 1");
    end
    if (SETTLE_W < 32'd1) begin : g_bad_settle_w
        $error("sr_latch_driver: SETTLE_W must be at least 1");
    end
    if (ERR_W < 32'd1) begin : g_bad_err_w
        $error("sr_latch_driver: ERR_W must be at least 1");
    end

    state_e           state_r,     state_s;
    logic             exp_q_r,     exp_q_s;
    logic             sel_s_r,     sel_s_s;
    logic             s_out_r,     s_out_s;
    logic             r_out_r,     r_out_s;
    logic             cmd_ready_r, cmd_ready_s;
    logic             done_r,      done_s;
    logic             err_r,       err_s;
    logic             q_seen_r,    q_seen_s;
    logic [ERR_W-1:0] err_cnt_r,   err_cnt_s;

    logic             accept_s;
    op_e              op_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_value_s;
    logic             tmr_zero_s;

    assign op_s     = op_e'(bus.cmd_op);
    assign accept_s = bus.cmd_valid && cmd_ready_r;

    sr_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load_s),
        .value (tmr_value_s),
        .zero  (tmr_zero_s)
    );

    // Next-state, next-output and timer-load decisions for the command FSM.
    always_comb begin
        state_s     = state_r;
        exp_q_s     = exp_q_r;
        sel_s_s     = sel_s_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        q_seen_s    = q_seen_r;
        err_cnt_s   = err_cnt_r;
        tmr_load_s  = 1'b0;
        tmr_value_s = PULSE_LD;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    // Opcode and Q are captured only here; later changes are ignored.
                    exp_q_s    = op_exp_q(op_s, q_in);
                    sel_s_s    = op_sel_s(op_s, q_in);
                    tmr_load_s = 1'b1;
                    if (op_drives(op_s)) begin
                        state_s     = DRIVE;
                        tmr_value_s = PULSE_LD;
                    end else begin
                        state_s     = SETTLE;
                        tmr_value_s = SETTLE_LD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            DRIVE: begin
                if (tmr_zero_s) begin
                    state_s     = SETTLE;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = SETTLE_LD;
                end else begin
                    state_s = DRIVE;
                end
            end

            SETTLE: begin
                if (tmr_zero_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = SETTLE;
                end
            end

            CHECK: begin
                state_s  = IDLE;
                q_seen_s = q_in;
                done_s   = 1'b1;
                if (q_in != exp_q_r) begin
                    err_s = 1'b1;
                    if (err_cnt_r != ERR_MAX) begin
                        err_cnt_s = err_cnt_r + ERR_W'(1'b1);
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                end else begin
                    err_s = 1'b0;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        // Line drive follows the state being entered, so the pulse and the
        // ready flag line up with the state the FSM will be in next cycle.
        s_out_s     = (state_s == DRIVE) &&  sel_s_s;
        r_out_s     = (state_s == DRIVE) && !sel_s_s;
        cmd_ready_s = (state_s == IDLE);
    end

    // State and registered outputs; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            exp_q_r     <= 1'b0;
            sel_s_r     <= 1'b0;
            s_out_r     <= 1'b0;
            r_out_r     <= 1'b0;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            q_seen_r    <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            exp_q_r     <= exp_q_s;
            sel_s_r     <= sel_s_s;
            s_out_r     <= s_out_s;
            r_out_r     <= r_out_s;
            cmd_ready_r <= cmd_ready_s;
            done_r      <= done_s;
            err_r       <= err_s;
            q_seen_r    <= q_seen_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign s_out         = s_out_r;
    assign r_out         = r_out_r;
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.q_seen    = q_seen_r;
    assign bus.err_count = err_cnt_r;

endmodule
